// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared types and constants for the sequential ALU.
//   opcode_t : 5-bit opcode encoding presented on select
//   state_t  : control FSM states
//   FLAG_*   : bit positions inside the 4-bit flags word {N, V, C, Z}
//   pack_flags() assembles a flags word from individual bits.
package alu_seq_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_SHL1  = 5'd2,
        OP_SHR1  = 5'd3,
        OP_CMP   = 5'd4,
        OP_AND   = 5'd5,
        OP_OR    = 5'd6,
        OP_XOR   = 5'd7,
        OP_NAND  = 5'd8,
        OP_NOR   = 5'd9,
        OP_XNOR  = 5'd10,
        OP_NOT   = 5'd11,
        OP_NEG   = 5'd12,
        OP_MOVYA = 5'd13,
        OP_SWAP  = 5'd14,
        OP_LOADA = 5'd15,
        OP_MUL   = 5'd16,
        OP_SHLN  = 5'd17,
        OP_SHRN  = 5'd18,
        OP_SMUL  = 5'd19
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_SHL,
        ST_SHR,
        ST_DONE
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    function automatic logic [3:0] pack_flags(input logic n, input logic v,
                                              input logic c, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if
//   Front-panel / result bus of the sequential ALU.
//   master : drives data, select, perform; observes busy, done, A, B, Y, flags
//   slave  : the ALU side (inputs and outputs reversed)
//   WIDTH  : datapath width of data, A, B and Y
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic [4:0]       select;
    logic             perform;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Y;
    logic [3:0]       flags;

    modport master (
        output data, select, perform,
        input  busy, done, A, B, Y, flags
    );

    modport slave (
        input  data, select, perform,
        output busy, done, A, B, Y, flags
    );
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul
//   Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
//   clk, reset : clock and asynchronous active-low reset
//   start      : latch a/b and begin; the first partial product is
//                accumulated on the start edge itself
//   a, b       : operands (WIDTH bits)
//   done       : high from WIDTH-1 edges after start until the next start
//   product    : 2*WIDTH-bit unsigned product, valid while done=1
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    // Step 1 happens on the start edge so that the final product is ready
    // one cycle before the caller's WIDTH-cycle deadline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_q  <= {{WIDTH{1'b0}}, a} << 1;
            mplier_q <= b >> 1;
            cnt_q    <= CNT_W'(1);
        end else if (cnt_q != '0 && cnt_q != CNT_W'(WIDTH)) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    assign done    = (cnt_q == CNT_W'(WIDTH));
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Clocked ALU with operand registers A/B, result register Y and flags
//   {N, V, C, Z}. Single-cycle logic/arithmetic ops complete on the accepting
//   edge; MUL, SHLN and SHRN run for several cycles under busy. Every accepted
//   op passes through DONE, which produces the one-cycle done pulse.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : alu_seq_if slave (data, select, perform in; busy, done, A, B, Y,
//           flags out)
//   WIDTH   : datapath width (>= 4)
//   SHAMT_W : width of the shift amount taken from B
//   Build option: define ALU_SEQ_SIGNED_MUL_EN to enable opcode 19 (SMUL),
//   a two's-complement multiply sharing the unsigned multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    alu_seq_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, y_q;
    logic [3:0]         flags_q;
    logic [WIDTH-1:0]   sh_q;
    logic [SHAMT_W-1:0] sh_left_q;

    logic               a_we, b_we, y_we;
    logic [WIDTH-1:0]   a_d, b_d, y_d;
    logic               c_d, v_d;
    logic               mul_start, sh_load, sh_step;

    logic               mul_done;
    logic [2*WIDTH-1:0] mul_p;

    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_c, alu_v;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .done    (mul_done),
        .product (mul_p)
    );

`ifdef ALU_SEQ_SIGNED_MUL_EN
    logic             smul_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [WIDTH-1:0] hi_s;
    logic             smul_fits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smul_q <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (mul_start) begin
            smul_q <= (bus.select == OP_SMUL);
            op_a_q <= a_q;
            op_b_q <= b_q;
        end
    end

    // Signed high half = unsigned high half minus each operand wherever the
    // other one is negative; the product fits when that high half is pure
    // sign extension of the low half.
    always_comb begin
        hi_s = mul_p[2*WIDTH-1:WIDTH];
        if (op_a_q[MSB]) hi_s = hi_s - op_b_q;
        if (op_b_q[MSB]) hi_s = hi_s - op_a_q;
    end
    assign smul_fits = (hi_s == {WIDTH{mul_p[MSB]}});
`endif

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    // Single-cycle datapath for opcodes 0-12.
    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.select)
            OP_ADD: begin
                alu_y = sum[MSB:0];
                alu_c = sum[WIDTH];
                alu_v = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_y = diff[MSB:0];
                alu_c = ~diff[WIDTH];
                alu_v = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_SHL1: begin
                alu_y = a_q << 1;
                alu_c = a_q[MSB];
            end
            OP_SHR1: begin
                alu_y = a_q >> 1;
                alu_c = a_q[0];
            end
            OP_CMP:  alu_y = {{(WIDTH-3){1'b0}}, a_q > b_q, a_q == b_q, a_q < b_q};
            OP_AND:  alu_y = a_q & b_q;
            OP_OR:   alu_y = a_q | b_q;
            OP_XOR:  alu_y = a_q ^ b_q;
            OP_NAND: alu_y = ~(a_q & b_q);
            OP_NOR:  alu_y = ~(a_q | b_q);
            OP_XNOR: alu_y = ~(a_q ^ b_q);
            OP_NOT:  alu_y = ~a_q;
            OP_NEG: begin
                alu_y = -a_q;
                alu_v = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        sh_load   = 1'b0;
        sh_step   = 1'b0;
        a_we      = 1'b0;
        a_d       = a_q;
        b_we      = 1'b0;
        b_d       = b_q;
        y_we      = 1'b0;
        y_d       = y_q;
        c_d       = 1'b0;
        v_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.perform) begin
                    state_d = ST_DONE;
                    case (bus.select)
                        OP_MUL: begin
                            state_d   = ST_MUL;
                            mul_start = 1'b1;
                        end
`ifdef ALU_SEQ_SIGNED_MUL_EN
                        OP_SMUL: begin
                            state_d   = ST_MUL;
                            mul_start = 1'b1;
                        end
`endif
                        OP_SHLN: begin
                            state_d = ST_SHL;
                            sh_load = 1'b1;
                        end
                        OP_SHRN: begin
                            state_d = ST_SHR;
                            sh_load = 1'b1;
                        end
                        OP_MOVYA: begin
                            a_we = 1'b1;
                            a_d  = y_q;
                        end
                        OP_SWAP: begin
                            a_we = 1'b1;
                            a_d  = b_q;
                            b_we = 1'b1;
                            b_d  = a_q;
                        end
                        OP_LOADA: begin
                            a_we = 1'b1;
                            a_d  = bus.data;
                        end
                        default: begin
                            if (bus.select <= OP_NEG) begin
                                y_we = 1'b1;
                                y_d  = alu_y;
                                c_d  = alu_c;
                                v_d  = alu_v;
                            end
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                    y_we    = 1'b1;
                    y_d     = mul_p[MSB:0];
`ifdef ALU_SEQ_SIGNED_MUL_EN
                    if (smul_q) v_d = ~smul_fits;
                    else        c_d = |mul_p[2*WIDTH-1:WIDTH];
`else
                    c_d = |mul_p[2*WIDTH-1:WIDTH];
`endif
                end
            end
            // The last single-position shift is folded into the Y write so
            // that Y lands exactly max(s,1) edges after acceptance.
            ST_SHL: begin
                if (sh_left_q == '0) begin
                    state_d = ST_DONE;
                    y_we    = 1'b1;
                    y_d     = sh_q;
                end else if (sh_left_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                    y_we    = 1'b1;
                    y_d     = sh_q << 1;
                    c_d     = sh_q[MSB];
                end else begin
                    sh_step = 1'b1;
                end
            end
            ST_SHR: begin
                if (sh_left_q == '0) begin
                    state_d = ST_DONE;
                    y_we    = 1'b1;
                    y_d     = sh_q;
                end else if (sh_left_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                    y_we    = 1'b1;
                    y_d     = sh_q >> 1;
                    c_d     = sh_q[0];
                end else begin
                    sh_step = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            y_q       <= '0;
            flags_q   <= '0;
            sh_q      <= '0;
            sh_left_q <= '0;
        end else begin
            if (a_we) a_q <= a_d;
            if (b_we) b_q <= b_d;
            if (y_we) begin
                y_q     <= y_d;
                flags_q <= pack_flags(y_d[MSB], v_d, c_d, y_d == '0);
            end
            if (sh_load) begin
                sh_q      <= a_q;
                sh_left_q <= b_q[SHAMT_W-1:0];
            end else if (sh_step) begin
                sh_q      <= (state_q == ST_SHL) ? (sh_q << 1) : (sh_q >> 1);
                sh_left_q <= sh_left_q - 1'b1;
            end
        end
    end

    assign bus.busy  = (state_q == ST_MUL) || (state_q == ST_SHL) || (state_q == ST_SHR);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.A     = a_q;
    assign bus.B     = b_q;
    assign bus.Y     = y_q;
    assign bus.flags = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Self-checking bench for alu_seq at WIDTH=8. A behavioural model computes
//   expected A, B, Y, flags and latency from integer arithmetic; directed
//   cases are followed by randomized ops with disturbances while busy.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_a = 0, m_b = 0, m_y = 0, m_f = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int to_signed8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference: update model registers for one op, return expected latency.
    task automatic model_op(input int op, input int d, output int lat);
        int a, b, y, s, sa, sb, p;
        bit c, v, wr;
        a = m_a; b = m_b;
        sa = to_signed8(a); sb = to_signed8(b);
        y = 0; c = 1'b0; v = 1'b0; wr = 1'b1; lat = 0;
        s = b % 8;
        case (op)
            OP_ADD:  begin p = a + b; y = p % 256; c = (p > 255);
                           v = (sa + sb > 127) || (sa + sb < -128); end
            OP_SUB:  begin y = (a - b + 256) % 256; c = (a >= b);
                           v = (sa - sb > 127) || (sa - sb < -128); end
            OP_SHL1: begin y = (a * 2) % 256; c = (a >= 128); end
            OP_SHR1: begin y = a / 2; c = (a % 2 == 1); end
            OP_CMP:  y = (a > b) ? 4 : ((a == b) ? 2 : 1);
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = 255 - (a & b);
            OP_NOR:  y = 255 - (a | b);
            OP_XNOR: y = 255 - (a ^ b);
            OP_NOT:  y = 255 - a;
            OP_NEG:  begin y = (256 - a) % 256; v = (a == 128); end
            OP_MOVYA: begin m_a = m_y; wr = 1'b0; end
            OP_SWAP:  begin m_a = b; m_b = a; wr = 1'b0; end
            OP_LOADA: begin m_a = d; wr = 1'b0; end
            OP_MUL:  begin p = a * b; y = p % 256; c = (p > 255); lat = 8; end
            OP_SHLN: begin lat = (s == 0) ? 1 : s; y = (a * (1 << s)) % 256;
                           c = (s != 0) && ((a >> (8 - s)) % 2 == 1); end
            OP_SHRN: begin lat = (s == 0) ? 1 : s; y = a >> s;
                           c = (s != 0) && ((a >> (s - 1)) % 2 == 1); end
`ifdef ALU_SEQ_SIGNED_MUL_EN
            OP_SMUL: begin p = sa * sb; y = (p + 65536) % 256;
                           v = (p > 127) || (p < -128); lat = 8; end
`endif
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_y = y;
            m_f = ((y >= 128) ? 8 : 0) + (v ? 4 : 0) + (c ? 2 : 0) + ((y == 0) ? 1 : 0);
        end
    endtask

    task automatic run_op(input int op, input int d, input bit glitch);
        int lat, waits;
        model_op(op, d, lat);
        @(negedge clk);
        bus.select  = 5'(op);
        bus.data    = 8'(d);
        bus.perform = 1'b1;
        @(negedge clk);
        bus.perform = 1'b0;
        waits = 0;
        while (bus.done !== 1'b1 && waits < 40) begin
            check("busy_during_op", int'(bus.busy), 1);
            if (glitch) begin
                bus.perform = 1'b1;
                bus.select  = 5'($urandom);
                bus.data    = 8'($urandom);
            end
            @(negedge clk);
            bus.perform = 1'b0;
            waits++;
        end
        check("done_seen", int'(bus.done), 1);
        check("latency", waits, lat);
        check("busy_at_done", int'(bus.busy), 0);
        check("A", int'(bus.A), m_a);
        check("B", int'(bus.B), m_b);
        check("Y", int'(bus.Y), m_y);
        check("flags", int'(bus.flags), m_f);
        @(negedge clk);
        check("done_one_cycle", int'(bus.done), 0);
    endtask

    task automatic set_ab(input int a, input int b);
        run_op(OP_LOADA, b, 1'b0);
        run_op(OP_SWAP, 0, 1'b0);
        run_op(OP_LOADA, a, 1'b0);
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_A"}, int'(bus.A), 0);
        check({tag, "_B"}, int'(bus.B), 0);
        check({tag, "_Y"}, int'(bus.Y), 0);
        check({tag, "_flags"}, int'(bus.flags), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones, y_before;
        bus.data = '0; bus.select = '0; bus.perform = 1'b0;
        repeat (2) @(negedge clk);
        check_zeroed("reset");
        reset = 1'b1;

        run_op(OP_LOADA, 'h7F, 1'b0);
        run_op(OP_SWAP, 0, 1'b0);
        run_op(OP_LOADA, 'h01, 1'b0);
        run_op(OP_ADD, 0, 1'b0);
        check("add_y", int'(bus.Y), 'h80);
        check("add_flags", int'(bus.flags), 'hC);

        set_ab('h05, 'h05);
        run_op(OP_SUB, 0, 1'b0);
        check("sub_y", int'(bus.Y), 'h00);
        check("sub_flags", int'(bus.flags), 'h3);
        set_ab('h03, 'h05);
        run_op(OP_CMP, 0, 1'b0);
        check("cmp_y", int'(bus.Y), 'h01);

        set_ab('h0F, 'h11);
        run_op(OP_MUL, 0, 1'b0);
        check("mul_y", int'(bus.Y), 'hFF);
        check("mul_flags", int'(bus.flags), 'h8);
        set_ab('h10, 'h10);
        run_op(OP_MUL, 0, 1'b1);
        check("mul_ovf_y", int'(bus.Y), 'h00);
        check("mul_ovf_flags", int'(bus.flags), 'h3);

        set_ab('h81, 'h03);
        run_op(OP_SHLN, 0, 1'b1);
        check("shln_y", int'(bus.Y), 'h08);
        check("shln_flags", int'(bus.flags), 'h0);
        set_ab('h81, 'h00);
        run_op(OP_SHLN, 0, 1'b0);
        check("shln0_y", int'(bus.Y), 'h81);
        set_ab('h81, 'h05);
        run_op(OP_SHRN, 0, 1'b1);

        y_before = m_y;
        set_ab('hFE, 'h03);
        run_op(OP_SMUL, 0, 1'b0);
`ifdef ALU_SEQ_SIGNED_MUL_EN
        check("smul_y", int'(bus.Y), 'hFA);
        check("smul_flags", int'(bus.flags), 'h8);
`else
        check("op19_y_held", int'(bus.Y), y_before);
`endif

        // Perform held high: every IDLE cycle accepts, DONE in between.
        dones = 0;
        @(negedge clk);
        bus.select = 5'd20; bus.perform = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        bus.perform = 1'b0;
        check("held_perform_dones", dones, 4);
        check("held_perform_y", int'(bus.Y), m_y);

        // Reset in the fourth cycle of a multiply.
        set_ab('h0F, 'h11);
        @(negedge clk);
        bus.select = 5'(OP_MUL); bus.perform = 1'b1;
        @(negedge clk);
        bus.perform = 1'b0;
        repeat (3) @(negedge clk);
        check("mul_busy_before_abort", int'(bus.busy), 1);
        #1 reset = 1'b0;
        #1 check_zeroed("abort");
        m_a = 0; m_b = 0; m_y = 0; m_f = 0;
        #1 reset = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("no_done_after_abort", dones, 0);
        run_op(OP_LOADA, 'h5A, 1'b0);

        repeat (200) begin
            run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
